// File: rtl/bundle_decode_stage_pkg.sv
// Shared types for the bundle decode stage:
// opcode constants, decoded-lane record and skid buffer state.
package bundle_decode_stage_pkg;

    localparam int DEC_XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [6:0]          op;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [DEC_XLEN-1:0] imm;
        logic [DEC_XLEN-1:0] pc;
    } dec_lane_t;

endpackage

// File: rtl/bundle_decode_stage_lane_decoder.sv
// Combinational decode of one instruction lane, plus the
// register read/write flags used for intra-bundle hazards.
module lane_decoder
    import bundle_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_lane_t       dec_o,
    output logic            writes_o,
    output logic            reads_rs1_o,
    output logic            reads_rs2_o,
    output logic            illegal_o
);

    logic [6:0]      opc;
    logic            sgn;
    logic            rd_nz;
    logic            legal;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;

    assign opc   = instr_i[6:0];
    assign sgn   = instr_i[31];
    assign rd_nz = (instr_i[11:7] != 5'd0);
    assign legal = (opc == OP_LOAD) || (opc == OP_STORE) ||
                   (opc == OP_JAL) || (opc == OP_BRANCH) ||
                   (opc == OP_IMM) || (opc == OP_REG);

    assign imm_i = {{(XLEN-12){sgn}}, instr_i[31:20]};
    assign imm_s = {{(XLEN-12){sgn}}, instr_i[31:25],
                    instr_i[11:7]};
    assign imm_b = {{(XLEN-12){sgn}}, instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){sgn}}, instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        dec_o       = '0;
        dec_o.pc    = pc_i;
        writes_o    = 1'b0;
        reads_rs1_o = 1'b0;
        reads_rs2_o = 1'b0;
        illegal_o   = 1'b0;
        if (legal) begin
            dec_o.op     = opc;
            dec_o.rd     = instr_i[11:7];
            dec_o.rs1    = instr_i[19:15];
            dec_o.rs2    = instr_i[24:20];
            dec_o.funct3 = instr_i[14:12];
            dec_o.funct7 = instr_i[31:25];
        end
        unique case (opc)
            OP_LOAD, OP_IMM: begin
                dec_o.imm   = imm_i;
                writes_o    = rd_nz;
                reads_rs1_o = 1'b1;
            end
            OP_STORE: begin
                dec_o.imm   = imm_s;
                dec_o.rd    = '0;
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
            end
            OP_BRANCH: begin
                dec_o.imm   = imm_b;
                dec_o.rd    = '0;
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
            end
            OP_JAL: begin
                dec_o.imm = imm_j;
                writes_o  = rd_nz;
            end
            OP_REG: begin
                writes_o    = rd_nz;
                reads_rs1_o = 1'b1;
                reads_rs2_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/bundle_decode_stage.sv
// Decodes a multi-lane issue bundle, flags intra-bundle RAW
// hazards and holds results in a two-entry skid buffer.
module bundle_decode_stage
    import bundle_decode_stage_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output dec_lane_t [LANES-1:0] out_dec,
    output logic [LANES-1:0]      out_dep,
    output logic [LANES-1:0]      out_illegal
);

    typedef struct packed {
        dec_lane_t [LANES-1:0] dec;
        logic [LANES-1:0]      dep;
        logic [LANES-1:0]      ill;
    } entry_t;

    dec_lane_t [LANES-1:0] dec;
    logic [LANES-1:0]      wr;
    logic [LANES-1:0]      r1;
    logic [LANES-1:0]      r2;
    logic [LANES-1:0]      ill;
    logic [LANES-1:0]      dep;
    entry_t                new_e;

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        out_valid_q;
    entry_t      head_q;
    entry_t      tail_q;
    logic        acc;
    logic        deq;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [XLEN-1:0] lane_pc;
        assign lane_pc = in_pc + XLEN'(4 * g);
        lane_decoder #(.XLEN(XLEN)) u_dec (
            .instr_i     (in_instr[g*XLEN +: XLEN]),
            .pc_i        (lane_pc),
            .dec_o       (dec[g]),
            .writes_o    (wr[g]),
            .reads_rs1_o (r1[g]),
            .reads_rs2_o (r2[g]),
            .illegal_o   (ill[g])
        );
    end

    // wr[] already excludes x0, so rd==0 never raises a hazard
    always_comb begin
        dep = '0;
        for (int i = 1; i < LANES; i++) begin
            for (int j = 0; j < i; j++) begin
                if (wr[j] &&
                    ((r1[i] && dec[i].rs1 == dec[j].rd) ||
                     (r2[i] && dec[i].rs2 == dec[j].rd)))
                    dep[i] = 1'b1;
            end
        end
    end

    assign new_e = {dec, dep, ill};
    assign acc   = in_valid && in_ready_q && !flush;
    assign deq   = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            unique case (state_q)
                SKID_EMPTY: if (acc) state_d = SKID_ONE;
                SKID_ONE: begin
                    if (acc && !deq)      state_d = SKID_TWO;
                    else if (!acc && deq) state_d = SKID_EMPTY;
                end
                SKID_TWO: if (deq) state_d = SKID_ONE;
                default:  state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID_TWO);
            out_valid_q <= (state_d != SKID_EMPTY);
            if (!flush) begin
                if (state_q == SKID_TWO) begin
                    if (deq) head_q <= tail_q;
                end else if (acc) begin
                    if (state_q == SKID_EMPTY || deq)
                        head_q <= new_e;
                    else
                        tail_q <= new_e;
                end
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_dec     = head_q.dec;
    assign out_dep     = head_q.dep;
    assign out_illegal = head_q.ill;

endmodule

// File: tb/tb_bundle_decode_stage.sv
// Randomized bench for bundle_decode_stage against a
// queue-based reference model of decode and buffering.
module tb_bundle_decode_stage;
    import bundle_decode_stage_pkg::*;

    localparam int L  = 2;
    localparam int XL = 32;

    typedef struct packed {
        dec_lane_t [L-1:0] dec;
        logic [L-1:0]      dep;
        logic [L-1:0]      ill;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [L*XL-1:0]   in_instr = '0;
    logic [XL-1:0]     in_pc = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    dec_lane_t [L-1:0] out_dec;
    logic [L-1:0]      out_dep;
    logic [L-1:0]      out_illegal;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    bundle_decode_stage #(.LANES(L), .XLEN(XL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dec     (out_dec),
        .out_dep     (out_dep),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Immediates built as plain signed integers from the field values.
    function automatic void ref_lane(
        input  logic [31:0] ins,
        input  logic [31:0] pc,
        output dec_lane_t   d,
        output bit          w,
        output bit          a,
        output bit          b,
        output bit          il
    );
        int v;
        logic [6:0] opc;
        opc = ins[6:0];
        d = '0;
        w = 0; a = 0; b = 0; il = 0;
        v = 0;
        d.op     = opc;
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = ins[14:12];
        d.funct7 = ins[31:25];
        case (opc)
            OP_LOAD, OP_IMM: begin
                v = int'(ins[31:20]);
                if (ins[31]) v -= 4096;
                w = 1; a = 1;
            end
            OP_STORE: begin
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (ins[31]) v -= 4096;
                d.rd = 0; a = 1; b = 1;
            end
            OP_BRANCH: begin
                v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
                d.rd = 0; a = 1; b = 1;
            end
            OP_JAL: begin
                v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
                if (ins[31]) v -= 1048576;
                w = 1;
            end
            OP_REG: begin
                w = 1; a = 1; b = 1;
            end
            default: begin
                d = '0;
                il = 1;
            end
        endcase
        d.imm = 32'(v);
        d.pc  = pc;
    endfunction

    function automatic exp_t ref_bundle(
        input logic [L*XL-1:0] bun,
        input logic [XL-1:0]   pc
    );
        exp_t        e;
        dec_lane_t   d;
        bit          w, a, b, il;
        logic [31:0] written;
        logic [31:0] rmask;
        e = '0;
        written = '0;
        for (int i = 0; i < L; i++) begin
            ref_lane(bun[i*XL +: XL], pc + 32'(4 * i), d, w, a, b, il);
            e.dec[i] = d;
            e.ill[i] = il;
            rmask = '0;
            if (a) rmask = rmask | (32'(1) << d.rs1);
            if (b) rmask = rmask | (32'(1) << d.rs2);
            e.dep[i] = |(rmask & written);
            if (w) written = written | (32'(1) << d.rd);
            written[0] = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: w[6:0] = OP_LOAD;
            1: w[6:0] = OP_STORE;
            2: w[6:0] = OP_JAL;
            3: w[6:0] = OP_BRANCH;
            4: w[6:0] = OP_IMM;
            5: w[6:0] = OP_REG;
            default: w[6:0] = 7'h7F;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // Called at a falling edge with inputs stable; steps the model
    // across the next rising edge.
    task automatic advance();
        bit   acc, deq;
        exp_t e;
        acc = in_valid && (q.size() < 2) && !flush;
        deq = (q.size() > 0) && out_ready;
        e = ref_bundle(in_instr, in_pc);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic load_one(input logic [L*XL-1:0] b,
                            input logic [XL-1:0] pc);
        in_valid  = 1'b1;
        in_instr  = b;
        in_pc     = pc;
        out_ready = 1'b0;
        advance();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        advance();
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL rst_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL rst_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_total++;
        if (out_dec !== '0)
            $display("FAIL rst_out_dec: got %h want 0", out_dec);
        else n_pass++;
        n_total++;
        if (out_dep !== '0)
            $display("FAIL rst_out_dep: got %b want 0", out_dep);
        else n_pass++;
        n_total++;
        if (out_illegal !== '0)
            $display("FAIL rst_out_illegal: got %b want 0", out_illegal);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_dep();
        exp_t e;
        e = ref_bundle({32'h00108133, 32'h00500093}, 32'h0);
        load_one({32'h00108133, 32'h00500093}, 32'h0);
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL dep_valid: got %b want 1", out_valid);
        else n_pass++;
        n_total++;
        if (out_dec[0].imm !== 32'd5 || out_dec[0].rd !== 5'd1)
            $display("FAIL dep_lane0: imm %h rd %0d want 5 1",
                     out_dec[0].imm, out_dec[0].rd);
        else n_pass++;
        n_total++;
        if (out_dec[1].rs1 !== 5'd1 || out_dec[1].rs2 !== 5'd1)
            $display("FAIL dep_lane1: rs1 %0d rs2 %0d want 1 1",
                     out_dec[1].rs1, out_dec[1].rs2);
        else n_pass++;
        n_total++;
        if (out_dep !== 2'b10)
            $display("FAIL dep_bits: got %b want 10", out_dep);
        else n_pass++;
        n_total++;
        if ({out_dec, out_dep, out_illegal} !== e)
            $display("FAIL dep_model: got %h want %h",
                     {out_dec, out_dep, out_illegal}, e);
        else n_pass++;
        drain();
    endtask

    task automatic test_branch_jal();
        load_one({32'h0080006F, 32'hFE000EE3}, 32'h100);
        n_total++;
        if (out_dec[0].imm !== 32'hFFFFFFFC || out_dec[1].imm !== 32'h8)
            $display("FAIL bj_imm: got %h %h want fffffffc 8",
                     out_dec[0].imm, out_dec[1].imm);
        else n_pass++;
        n_total++;
        if (out_dec[0].rd !== 5'd0 || out_dec[1].rd !== 5'd0)
            $display("FAIL bj_rd: got %0d %0d want 0 0",
                     out_dec[0].rd, out_dec[1].rd);
        else n_pass++;
        n_total++;
        if (out_dec[0].pc !== 32'h100 || out_dec[1].pc !== 32'h104)
            $display("FAIL bj_pc: got %h %h want 100 104",
                     out_dec[0].pc, out_dec[1].pc);
        else n_pass++;
        n_total++;
        if (out_dep !== 2'b00 || out_illegal !== 2'b00)
            $display("FAIL bj_flags: dep %b ill %b want 00 00",
                     out_dep, out_illegal);
        else n_pass++;
        drain();
    endtask

    task automatic test_illegal();
        dec_lane_t z;
        z = '0;
        z.pc = 32'h200;
        load_one({32'h00500093, 32'h00000000}, 32'h200);
        n_total++;
        if (out_illegal !== 2'b01)
            $display("FAIL ill_bits: got %b want 01", out_illegal);
        else n_pass++;
        n_total++;
        if (out_dec[0] !== z)
            $display("FAIL ill_fields: got %h want %h", out_dec[0], z);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [L*XL-1:0] bun[3];
        logic [XL-1:0]   pcs[3];
        exp_t            ex[3];
        int              idx = 0;
        int              nout = 0;
        for (int k = 0; k < 3; k++) begin
            bun[k] = {rand_instr(), rand_instr()};
            pcs[k] = $urandom & ~32'h3;
            ex[k]  = ref_bundle(bun[k], pcs[k]);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                n_total++;
                if (in_ready !== 1'b0)
                    $display("FAIL b2b_full: in_ready %b want 0", in_ready);
                else n_pass++;
            end
            n_total++;
            if (out_valid !== (q.size() > 0))
                $display("FAIL b2b_valid: got %b want %b",
                         out_valid, q.size() > 0);
            else n_pass++;
            if (out_valid && out_ready) begin
                n_total++;
                if (nout >= 3 || {out_dec, out_dep, out_illegal} !== ex[nout])
                    $display("FAIL b2b_order: bundle %0d got %h",
                             nout, {out_dec, out_dep, out_illegal});
                else n_pass++;
                nout++;
            end
            in_valid = (idx < 3);
            if (idx < 3) begin
                in_instr = bun[idx];
                in_pc    = pcs[idx];
            end
            if (in_valid && q.size() < 2) idx++;
            advance();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_total++;
        if (nout !== 3)
            $display("FAIL b2b_count: emitted %0d want 3", nout);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_instr = {rand_instr(), rand_instr()};
            in_pc    = $urandom;
            advance();
            @(negedge clk);
        end
        n_total++;
        if (in_ready !== 1'b0)
            $display("FAIL flush_pre: in_ready %b want 0", in_ready);
        else n_pass++;
        flush    = 1'b1;
        in_instr = {rand_instr(), rand_instr()};
        advance();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_post: valid %b ready %b want 0 1",
                     out_valid, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        repeat (2) begin
            n_total++;
            if (out_valid !== 1'b0)
                $display("FAIL flush_emit: out_valid %b want 0", out_valid);
            else n_pass++;
            advance();
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        load_one({rand_instr(), rand_instr()}, $urandom);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_ctl: valid %b ready %b want 0 1",
                     out_valid, in_ready);
        else n_pass++;
        n_total++;
        if ({out_dec, out_dep, out_illegal} !== '0)
            $display("FAIL rstmid_data: got %h want 0",
                     {out_dec, out_dep, out_illegal});
        else n_pass++;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_instr = {rand_instr(), rand_instr()};
        in_pc    = $urandom;
        e = ref_bundle(in_instr, in_pc);
        advance();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1)
            $display("FAIL rstmid_latency: out_valid %b want 1", out_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({out_dec, out_dep, out_illegal} !== e)
            $display("FAIL rstmid_out: got %h want %h",
                     {out_dec, out_dep, out_illegal}, e);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_total++;
            if (in_ready !== (q.size() < 2))
                $display("FAIL rnd_ready c%0d: got %b want %b",
                         cyc, in_ready, q.size() < 2);
            else n_pass++;
            n_total++;
            if (out_valid !== (q.size() > 0))
                $display("FAIL rnd_valid c%0d: got %b want %b",
                         cyc, out_valid, q.size() > 0);
            else n_pass++;
            if (q.size() > 0) begin
                n_total++;
                if ({out_dec, out_dep, out_illegal} !== q[0])
                    $display("FAIL rnd_data c%0d: got %h want %h", cyc,
                             {out_dec, out_dep, out_illegal}, q[0]);
                else n_pass++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_instr  = {rand_instr(), rand_instr()};
            in_pc     = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            advance();
            @(negedge clk);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dep();
        test_branch_jal();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
